// File: rtl/accum_pkg.sv
// Shared constants and the reader state encoding for the accumulator column drain engine.
package accum_pkg;
  localparam int DATA_WIDTH     = 8;
  localparam int MAX_OUT_ROWS   = 128;
  localparam int MAX_OUT_COLS   = 128;
  localparam int SYS_ARR_WIDTH  = 16;
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * ((MAX_OUT_COLS + SYS_ARR_WIDTH - 1) / SYS_ARR_WIDTH);
  localparam int ADDR_WIDTH     = $clog2(NUM_ACCUM_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;
endpackage

// File: rtl/accum_skid_fifo.sv
// Two-entry FIFO holding {last, data} beats between the column read port and the output.
module accum_skid_fifo
  import accum_pkg::*;
#(
  parameter int W = DATA_WIDTH + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/accum_col_reader.sv
// Drains a contiguous, wrapping range of one accumulator column onto a valid/ready stream,
// optionally clearing each entry once its data has been captured.
module accum_col_reader
  import accum_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output reader_state_e         dbg_state
);
  // Valid/ready: a beat moves on a rising edge with out_valid && out_ready; once out_valid
  // rises it stays high with out_data/out_last unchanged until that handshake happens.

  reader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d, issued_inc;
  logic                  clear_q, clear_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [ADDR_WIDTH-1:0] prev_addr_q, prev_addr_d;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  pop, can_issue, issue_last;

  accum_skid_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data ({inflight_last_q, rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    out_valid  = (fifo_count != 2'd0);
    out_data   = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    out_last   = out_valid & fifo_head[DATA_WIDTH];
    pop        = out_valid & out_ready;
    // A pop this cycle frees a slot before the issued read lands, keeping 1 beat/cycle.
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    can_issue  = occupancy < (3'd2 + {2'b00, pop});
    issued_inc = issued_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    issue_last = (issued_inc == num_q);
    rd_en      = (state_q == ST_READ) && can_issue;
    rd_addr    = base_q + issued_q[ADDR_WIDTH-1:0];
    clr_en     = inflight_q & clear_q;
    clr_addr   = prev_addr_q;
    busy       = (state_q == ST_READ) || (state_q == ST_FLUSH);
    done       = (state_q == ST_DONE);
    dbg_state  = state_q;

    state_d         = state_q;
    base_d          = base_q;
    num_d           = num_q;
    clear_d         = clear_q;
    issued_d        = issued_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en & issue_last;
    prev_addr_d     = rd_en ? rd_addr : prev_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_rows;
          clear_d  = clear_en;
          issued_d = '0;
          state_d  = (num_rows == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (rd_en) begin
          issued_d = issued_inc;
          if (issue_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pop && fifo_head[DATA_WIDTH]) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      num_q           <= '0;
      clear_q         <= 1'b0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      prev_addr_q     <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      num_q           <= num_d;
      clear_q         <= clear_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      prev_addr_q     <= prev_addr_d;
    end
  end
endmodule

// File: tb/tb_accum_col_reader.sv
// Directed bench for accum_col_reader with a behavioural column and an expected-beat scoreboard.
module tb_accum_col_reader;
  import accum_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          clear_en;
  logic          busy, done, rd_en, clr_en, out_valid, out_ready, out_last;
  logic [AW-1:0] rd_addr, clr_addr;
  logic [DW-1:0] rd_data, out_data;
  reader_state_e dbg_state;

  always #5 clk = ~clk;

  accum_col_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .clear_en  (clear_en),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a < 8) return DW'(10 + a);
    return DW'((a * 7 + 3) & 8'hFF);
  endfunction

  // Behavioural column: one-cycle read latency, per-entry clear.
  bit col_cleared [NUM_ACCUM_ROWS];
  always @(posedge clk) begin
    if (rd_en) rd_data <= col_cleared[rd_addr] ? '0 : init_val(int'(rd_addr));
    if (clr_en) col_cleared[clr_addr] <= 1'b1;
  end

  // Scoreboard state
  bit             ref_cleared [NUM_ACCUM_ROWS];
  logic [DW:0]    exp_q [$];
  logic [AW-1:0]  addr_q [$];
  logic [AW-1:0]  clr_q [$];
  int             checks = 0;
  int             errors = 0;
  int             issued_cnt, accepted_cnt, cyc, hs_first_cyc, hs_last_cyc, phase;
  logic           mon_en, cur_clear, empty_due, done_seen, prev_rd_en, last_hs_prev;
  int             ready_mode;
  logic [3:0]     ready_pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [DW:0]   e;
    logic [AW-1:0] a;
    logic          exp_done, last_now;
    @(negedge clk);
    if (!mon_en) return;
    last_now = 1'b0;
    exp_done = last_hs_prev | empty_due;
    check("done", done, exp_done);
    if (done === 1'b1) done_seen = 1'b1;
    empty_due = 1'b0;
    if (rd_en === 1'b1) begin
      issued_cnt++;
      if (addr_q.size() == 0) check("rd_en_unexpected", rd_en, 0);
      else begin
        a = addr_q.pop_front();
        check("rd_addr", rd_addr, a);
      end
    end
    if (clr_en === 1'b1) begin
      if (!cur_clear || clr_q.size() == 0) check("clr_unexpected", clr_en, 0);
      else begin
        a = clr_q.pop_front();
        check("clr_addr", clr_addr, a);
        check("clr_after_rd", prev_rd_en, 1);
      end
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) check("beat_unexpected", out_valid, 0);
      else if (out_ready) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[DW-1:0]);
        check("out_last", out_last, e[DW]);
        accepted_cnt++;
        if (accepted_cnt == 1) hs_first_cyc = cyc;
        hs_last_cyc = cyc;
        last_now = e[DW];
      end else begin
        e = exp_q[0];
        check("stall_data", out_data, e[DW-1:0]);
        check("stall_last", out_last, e[DW]);
      end
    end
    if (rd_en === 1'b1) check("read_ahead_le2", (issued_cnt - accepted_cnt) <= 2, 1);
    prev_rd_en   = rd_en;
    last_hs_prev = last_now;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (ready_mode == 0) out_ready = 1'b1;
    else begin
      out_ready = ready_pat[phase];
      phase = (phase + 1) % 4;
    end
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic start_drain(input int base, input int n, input logic clr);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (base + i) % NUM_ACCUM_ROWS;
      addr_q.push_back(AW'(a));
      exp_q.push_back({(i == n - 1), (ref_cleared[a] ? DW'(0) : init_val(a))});
      if (clr) clr_q.push_back(AW'(a));
    end
    cur_clear    = clr;
    issued_cnt   = 0;
    accepted_cnt = 0;
    hs_first_cyc = -1;
    done_seen    = 1'b0;
    base_addr    = AW'(base);
    num_rows     = (AW + 1)'(n);
    clear_en     = clr;
    start        = 1'b1;
    cycle();
    start = 1'b0;
    if (n == 0) empty_due = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done_seen; i++) cycle();
    check({tag, "_done_seen"}, done_seen, 1);
    cycle();
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
    check({tag, "_addr_q_empty"}, addr_q.size(), 0);
    check({tag, "_clr_q_empty"}, clr_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_clr_en"}, clr_en, 0);
    check({tag, "_clr_addr"}, clr_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; clear_en = 1'b0;
    out_ready = 1'b1; ready_mode = 0; phase = 0; cyc = 0;
    mon_en = 1'b0; cur_clear = 1'b0; empty_due = 1'b0; done_seen = 1'b0;
    prev_rd_en = 1'b0; last_hs_prev = 1'b0;
    issued_cnt = 0; accepted_cnt = 0; hs_first_cyc = -1; hs_last_cyc = -1;

    // Reset state
    repeat (3) advance();
    check_outputs_zero("reset");
    reset = 1'b1;
    mon_en = 1'b1;
    advance();

    // Basic 8-entry drain, full rate, latency and pulse timing
    start_drain(0, 8, 1'b0);
    sample();
    check("s1_busy_after_start", busy, 1);
    check("s1_valid_c1", out_valid, 0);
    advance();
    sample();
    check("s1_valid_c2", out_valid, 0);
    advance();
    sample();
    check("s1_valid_c3", out_valid, 1);
    advance();
    wait_done("s1", 40);
    check("s1_beats", accepted_cnt, 8);
    check("s1_back_to_back", hs_last_cyc - hs_first_cyc, 7);
    check("s1_busy_idle", busy, 0);

    // Wrapping range; a start while busy is ignored
    start_drain(1020, 6, 1'b0);
    base_addr = AW'(5);
    num_rows  = (AW + 1)'(2);
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done("s2", 40);
    check("s2_beats", accepted_cnt, 6);

    // Empty drain
    start_drain(0, 0, 1'b0);
    sample();
    check("s3_done", done, 1);
    check("s3_rd_en", rd_en, 0);
    check("s3_out_valid", out_valid, 0);
    check("s3_clr_en", clr_en, 0);
    advance();
    wait_done("s3", 5);
    check("s3_beats", accepted_cnt, 0);

    // Backpressure pattern 1,0,0,1
    ready_mode = 1;
    phase = 0;
    start_drain(0, 8, 1'b0);
    wait_done("s4", 80);
    check("s4_beats", accepted_cnt, 8);
    ready_mode = 0;
    advance();

    // Clear on read, then re-read the cleared entries
    start_drain(4, 3, 1'b1);
    wait_done("s5", 40);
    for (int a = 4; a < 7; a++) ref_cleared[a] = 1'b1;
    start_drain(4, 3, 1'b0);
    wait_done("s5_reread", 40);
    check("s5_reread_beats", accepted_cnt, 3);

    // Full column, starting mid-column so it wraps
    start_drain(512, NUM_ACCUM_ROWS, 1'b0);
    wait_done("s6", NUM_ACCUM_ROWS + 40);
    check("s6_beats", accepted_cnt, NUM_ACCUM_ROWS);

    // Reset mid-drain
    start_drain(100, 16, 1'b0);
    for (int i = 0; i < 30 && accepted_cnt < 3; i++) cycle();
    check("s7_three_beats", accepted_cnt, 3);
    reset = 1'b0;
    #1;
    check_outputs_zero("s7_abort");
    mon_en = 1'b0;
    exp_q.delete();
    addr_q.delete();
    clr_q.delete();
    advance();
    reset = 1'b1;
    mon_en = 1'b1;
    last_hs_prev = 1'b0;
    prev_rd_en = 1'b0;
    done_seen = 1'b0;
    repeat (4) cycle();
    check("s7_no_done", done_seen, 0);
    start_drain(0, 8, 1'b0);
    wait_done("s7_restart", 40);
    check("s7_restart_beats", accepted_cnt, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
